aq_reduce_axis_out: RTL and testbench

//  Downstream neighbour of the reduce pipeline: converts its push-only pixel stream
//  (OE/FSYNC/LAST/32-bit ARGB, no back-pressure) into an AXI4-Stream master.

---
 rtl/aq_reduce_axis_out.sv | 176 +++++++++++++++++
 tb/tb_aq_reduce_axis_out.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_reduce_axis_out.sv
// Push-only pixel stream to AXI4-Stream master through an elastic FWFT FIFO.
// Optional build macro AQ_REDUCE_AXIS_FSYNC_FLUSH_EN: DIN_FSYNC discards queued pixels.
module aq_reduce_axis_out #(
  parameter int FIFO_AW = 9
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [15:0]        CNV_X,
  input  logic               DIN_OE,
  input  logic               DIN_FSYNC,
  input  logic               DIN_LAST,
  input  logic [31:0]        DIN,
  output logic               M_AXIS_TVALID,
  input  logic               M_AXIS_TREADY,
  output logic [31:0]        M_AXIS_TDATA,
  output logic               M_AXIS_TUSER,
  output logic               M_AXIS_TLAST,
  output logic [FIFO_AW:0]   FIFO_LEVEL,
  output logic               OVF_STS,
  input  logic               OVF_CLR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] CNT_ZERO = {(FIFO_AW+1){1'b0}};

  logic [15:0]        col_r;
  logic [15:0]        col_eff_s;
  logic [15:0]        col_nxt_s;
  logic               sof_arm_r;
  logic               arm_eff_s;
  logic               arm_nxt_s;
  logic               px_tuser_s;
  logic               px_tlast_s;

  logic [33:0]        mem_r [DEPTH];
  logic               wr_vld_r;
  logic [FIFO_AW-1:0] wr_addr_r;
  logic [33:0]        wr_data_r;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   ram_cnt_r;
  logic [FIFO_AW:0]   landed_s;
  logic [FIFO_AW:0]   cnt_nxt_s;
  logic [FIFO_AW:0]   level_r;

  logic               full_s;
  logic               push_s;
  logic               drop_s;
  logic               pop_s;
  logic               flush_s;
  logic               tvalid_nxt_s;

  logic               tvalid_r;
  logic [31:0]        tdata_r;
  logic               tuser_r;
  logic               tlast_r;
  logic               ovf_r;

  // Frame/line tagging: FSYNC takes effect before a same-cycle pixel.
  always_comb begin
    col_eff_s  = DIN_FSYNC ? 16'd0 : col_r;
    arm_eff_s  = DIN_FSYNC | sof_arm_r;
    px_tuser_s = arm_eff_s;
    px_tlast_s = (col_eff_s == (CNV_X - 16'd1)) | DIN_LAST;
    if (DIN_OE) begin
      col_nxt_s = px_tlast_s ? 16'd0 : (col_eff_s + 16'd1);
      arm_nxt_s = 1'b0;
    end else begin
      col_nxt_s = col_eff_s;
      arm_nxt_s = arm_eff_s;
    end
  end

  // FIFO control; the write lands one cycle after acceptance, so only landed entries pop.
  always_comb begin
    full_s   = (ram_cnt_r == FULL_CNT);
    landed_s = ram_cnt_r - {{FIFO_AW{1'b0}}, wr_vld_r};
`ifdef AQ_REDUCE_AXIS_FSYNC_FLUSH_EN
    flush_s  = DIN_FSYNC & ((ram_cnt_r != CNT_ZERO) | tvalid_r);
`else
    flush_s  = 1'b0;
`endif
    push_s   = DIN_OE & (~full_s | flush_s);
    drop_s   = DIN_OE & full_s & ~flush_s;
    pop_s    = (landed_s != CNT_ZERO) & (~tvalid_r | M_AXIS_TREADY) & ~flush_s;
    if (flush_s) begin
      cnt_nxt_s = {{FIFO_AW{1'b0}}, push_s};
    end else begin
      cnt_nxt_s = ram_cnt_r + {{FIFO_AW{1'b0}}, push_s} - {{FIFO_AW{1'b0}}, pop_s};
    end
    if (flush_s) begin
      tvalid_nxt_s = 1'b0;
    end else if (pop_s) begin
      tvalid_nxt_s = 1'b1;
    end else if (M_AXIS_TREADY) begin
      tvalid_nxt_s = 1'b0;
    end else begin
      tvalid_nxt_s = tvalid_r;
    end
  end

  // Column counter and start-of-frame arm
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_r     <= 16'd0;
      sof_arm_r <= 1'b0;
    end else begin
      col_r     <= col_nxt_s;
      sof_arm_r <= arm_nxt_s;
    end
  end

  // Write pipeline, pointers and RAM occupancy
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_vld_r  <= 1'b0;
      wr_addr_r <= {FIFO_AW{1'b0}};
      wr_data_r <= 34'd0;
      wr_ptr_r  <= {FIFO_AW{1'b0}};
      rd_ptr_r  <= {FIFO_AW{1'b0}};
      ram_cnt_r <= CNT_ZERO;
    end else begin
      wr_vld_r <= push_s;
      if (push_s) begin
        wr_addr_r <= wr_ptr_r;
        wr_data_r <= {px_tuser_s, px_tlast_s, DIN};
        wr_ptr_r  <= wr_ptr_r + FIFO_AW'(1'b1);
      end
      if (flush_s) begin
        rd_ptr_r <= wr_ptr_r;
      end else if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FIFO_AW'(1'b1);
      end
      ram_cnt_r <= cnt_nxt_s;
    end
  end

  // Pixel storage, simple dual-port
  always_ff @(posedge CLK) begin
    if (wr_vld_r) begin
      mem_r[wr_addr_r] <= wr_data_r;
    end
  end

  // Output register (synchronous RAM read), level and sticky overflow
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tvalid_r <= 1'b0;
      tdata_r  <= 32'd0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      level_r  <= CNT_ZERO;
      ovf_r    <= 1'b0;
    end else begin
      tvalid_r <= tvalid_nxt_s;
      level_r  <= cnt_nxt_s + {{FIFO_AW{1'b0}}, tvalid_nxt_s};
      if (pop_s) begin
        {tuser_r, tlast_r, tdata_r} <= mem_r[rd_ptr_r];
      end
      if (drop_s | flush_s) begin
        ovf_r <= 1'b1;
      end else if (OVF_CLR) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign M_AXIS_TVALID = tvalid_r;
  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TUSER  = tuser_r;
  assign M_AXIS_TLAST  = tlast_r;
  assign FIFO_LEVEL    = level_r;
  assign OVF_STS       = ovf_r;

endmodule

// File: tb/tb_aq_reduce_axis_out.sv
// Scoreboard bench for aq_reduce_axis_out (FIFO_AW=3); expected beats are queued at drive time.
module tb_aq_reduce_axis_out;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [15:0]   CNV_X = 16'd4;
  logic          DIN_OE = 1'b0;
  logic          DIN_FSYNC = 1'b0;
  logic          DIN_LAST = 1'b0;
  logic [31:0]   DIN = 32'd0;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY = 1'b0;
  logic [31:0]   M_AXIS_TDATA;
  logic          M_AXIS_TUSER;
  logic          M_AXIS_TLAST;
  logic [AW:0]   FIFO_LEVEL;
  logic          OVF_STS;
  logic          OVF_CLR = 1'b0;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_mode = 0;
  bit          stab_en = 1'b0;
  logic [15:0] m_col = 16'd0;
  logic        m_arm = 1'b0;
  logic [33:0] sb[$];
  int          tu_cnt = 0;
  int          tl_cnt = 0;
  logic        hold_v = 1'b0;
  logic [33:0] held_w = 34'd0;

  aq_reduce_axis_out #(.FIFO_AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CNV_X(CNV_X),
    .DIN_OE(DIN_OE), .DIN_FSYNC(DIN_FSYNC), .DIN_LAST(DIN_LAST), .DIN(DIN),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
    .FIFO_LEVEL(FIFO_LEVEL), .OVF_STS(OVF_STS), .OVF_CLR(OVF_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sink ready: 0 = held low, 1 = held high, 2 = random 30% duty
  always @(posedge CLK) begin
    #2;
    case (rdy_mode)
      0:       M_AXIS_TREADY = 1'b0;
      1:       M_AXIS_TREADY = 1'b1;
      default: M_AXIS_TREADY = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Beat scoreboard and stall-stability monitor
  always @(negedge CLK) begin
    logic [33:0] exp_w;
    logic [33:0] cur_w;
    cur_w = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
    if (stab_en && hold_v) begin
      check_eq("hold_valid", 64'(M_AXIS_TVALID), 64'd1);
      check_eq("hold_data", 64'(cur_w), 64'(held_w));
    end
    hold_v = stab_en && M_AXIS_TVALID && !M_AXIS_TREADY;
    held_w = cur_w;
    if (RST_N && M_AXIS_TVALID && M_AXIS_TREADY) begin
      check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        check_eq("beat", 64'(cur_w), 64'(exp_w));
        if (M_AXIS_TUSER) tu_cnt++;
        if (M_AXIS_TLAST) tl_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drive_px(input logic [31:0] d, input logic fs, input logic lst, input bit store);
    logic tu;
    logic tl;
    if (fs) begin
      m_col = 16'd0;
      m_arm = 1'b1;
    end
    tu = m_arm;
    tl = (m_col == (CNV_X - 16'd1)) || lst;
    m_arm = 1'b0;
    m_col = tl ? 16'd0 : (m_col + 16'd1);
    if (store) sb.push_back({tu, tl, d});
    DIN_OE = 1'b1; DIN_FSYNC = fs; DIN_LAST = lst; DIN = d;
    cyc();
    DIN_OE = 1'b0; DIN_FSYNC = 1'b0; DIN_LAST = 1'b0;
  endtask

  task automatic fsync_only();
    m_col = 16'd0;
    m_arm = 1'b1;
    DIN_FSYNC = 1'b1;
    cyc();
    DIN_FSYNC = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || M_AXIS_TVALID); i++) cyc();
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tu0;
    int tl0;
    idle(2);
    check_eq("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    check_eq("rst_tdata", 64'(M_AXIS_TDATA), 64'd0);
    check_eq("rst_tuser_tlast", 64'({M_AXIS_TUSER, M_AXIS_TLAST}), 64'd0);
    check_eq("rst_level", 64'(FIFO_LEVEL), 64'd0);
    check_eq("rst_ovf", 64'(OVF_STS), 64'd0);
    RST_N = 1'b1;
    stab_en = 1'b1;
    idle(2);

    // 1: basic line tagging and two-cycle latency
    rdy_mode = 1;
    CNV_X = 16'd4;
    fsync_only();
    for (int i = 0; i < 8; i++) begin
      drive_px(32'(i), 1'b0, 1'b0, 1'b1);
      if (i == 1) check_eq("lat_edge_n1", 64'(M_AXIS_TVALID), 64'd0);
      if (i == 2) check_eq("lat_edge_n2", 64'(M_AXIS_TVALID), 64'd1);
    end
    drain("t1_drain", 50);

    // 2: overflow with sink stalled; RAM 8 + output register 1 retained
    rdy_mode = 0;
    fsync_only();
    for (int i = 0; i < 10; i++) drive_px(32'h100 + 32'(i), 1'b0, 1'b0, (i < 9));
    idle(2);
    check_eq("t2_level", 64'(FIFO_LEVEL), 64'd9);
    check_eq("t2_ovf", 64'(OVF_STS), 64'd1);

    // 5: clear racing a drop loses; clear alone wins
    OVF_CLR = 1'b1;
    drive_px(32'h1FF, 1'b0, 1'b0, 1'b0);
    OVF_CLR = 1'b0;
    check_eq("t5_clr_vs_drop", 64'(OVF_STS), 64'd1);
    OVF_CLR = 1'b1;
    cyc();
    OVF_CLR = 1'b0;
    check_eq("t5_clr_alone", 64'(OVF_STS), 64'd0);
    rdy_mode = 1;
    drain("t2_drain", 50);

    // 4: DIN_LAST mid-line restarts the column count
    fsync_only();
    drive_px(32'h40, 1'b0, 1'b0, 1'b1);
    drive_px(32'h41, 1'b0, 1'b0, 1'b1);
    drive_px(32'h42, 1'b0, 1'b1, 1'b1);
    for (int i = 3; i < 7; i++) drive_px(32'h40 + 32'(i), 1'b0, 1'b0, 1'b1);
    drain("t4_drain", 50);

    // 3: random back-pressure, 3 frames of 5x3, FSYNC with first pixel
    CNV_X = 16'd5;
    rdy_mode = 2;
    tu0 = tu_cnt;
    tl0 = tl_cnt;
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 5; c++) begin
          drive_px($urandom, (r == 0 && c == 0), 1'b0, 1'b1);
          idle(4);
        end
    drain("t3_drain", 3000);
    check_eq("t3_tuser_count", 64'(tu_cnt - tu0), 64'd3);
    check_eq("t3_tlast_count", 64'(tl_cnt - tl0), 64'd9);
    check_eq("t3_no_ovf", 64'(OVF_STS), 64'd0);

    // 6: FSYNC and reset with pixels queued
    stab_en = 1'b0;
    rdy_mode = 0;
    CNV_X = 16'd4;
    fsync_only();
    for (int i = 0; i < 5; i++) drive_px(32'h600 + 32'(i), 1'b0, 1'b0, 1'b1);
    idle(3);
    check_eq("t6_level5", 64'(FIFO_LEVEL), 64'd5);
    fsync_only();
`ifdef AQ_REDUCE_AXIS_FSYNC_FLUSH_EN
    check_eq("t6_flush_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    check_eq("t6_flush_level", 64'(FIFO_LEVEL), 64'd0);
    check_eq("t6_flush_ovf", 64'(OVF_STS), 64'd1);
    sb.delete();
    OVF_CLR = 1'b1;
    cyc();
    OVF_CLR = 1'b0;
`else
    check_eq("t6_fsync_keeps", 64'(FIFO_LEVEL), 64'd5);
    check_eq("t6_fsync_no_ovf", 64'(OVF_STS), 64'd0);
    rdy_mode = 1;
    drain("t6_fsync_drain", 50);
    rdy_mode = 0;
`endif
    for (int i = 0; i < 5; i++) drive_px(32'h700 + 32'(i), 1'b0, 1'b0, 1'b1);
    idle(3);
    check_eq("t6_level5b", 64'(FIFO_LEVEL), 64'd5);
    RST_N = 1'b0;
    #1;
    check_eq("t6_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    check_eq("t6_rst_level", 64'(FIFO_LEVEL), 64'd0);
    cyc();
    RST_N = 1'b1;
    sb.delete();
    m_col = 16'd0;
    m_arm = 1'b0;
    rdy_mode = 1;
    drive_px(32'h800, 1'b0, 1'b0, 1'b1);
    drive_px(32'h801, 1'b0, 1'b0, 1'b1);
    drain("t6_post_rst_drain", 50);
    check_eq("t6_ovf_final", 64'(OVF_STS), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
